// File: rtl/dsm_dac_mc.sv
// dsm_dac_mc: multichannel first-order delta-sigma DAC with shadowed, tick-synchronous code updates
module dsm_dac_mc #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 2,
  parameter int DIV_W = 8,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [DIV_W-1:0]    div,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] dac_out,
  output logic                frame
);
  localparam int NP = 2 ** CH_W;
  logic [DIV_W-1:0]    cnt;
  logic [WIDTH-1:0]    fcnt;
  logic                tick;
  logic [CHANNELS-1:0] pending;
  logic [NP-1:0]       pend_ext;
  assign tick = enable && cnt >= div;
  // out-of-range channel numbers see a never-pending slot, so they read ready and are dropped
  always_comb begin
    pend_ext = '0;
    pend_ext[CHANNELS-1:0] = pending;
  end
  assign wr_ready = !pend_ext[wr_chan];
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      fcnt <= '0;
      frame <= 1'b0;
    end else begin
      cnt <= (tick || !enable) ? '0 : cnt + 1'b1;
      frame <= tick && (&fcnt);
      if (tick) fcnt <= fcnt + 1'b1;
    end
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] shadow, active, acc;
    logic [WIDTH:0]   sum;
    logic             p, d, wr_en;
    assign sum = {1'b0, acc} + {1'b0, active};
    assign wr_en = wr_valid && wr_ready && wr_chan == CH_W'(g);
    assign pending[g] = p;
    assign dac_out[g] = d;
    // a write is only accepted while not pending, so the transfer clear and the write set never collide
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow <= '0;
        active <= '0;
        acc <= {1'b1, {(WIDTH-1){1'b0}}};
        p <= 1'b0;
        d <= 1'b0;
      end else begin
        if (tick) begin
          {d, acc} <= sum;
          if (p) begin
            active <= shadow;
            p <= 1'b0;
          end
        end
        if (wr_en) begin
          shadow <= wr_data;
          p <= 1'b1;
        end
      end
    end
  end
endmodule
